gcd_engine: RTL
===============

# gcd_engine

Iterative subtractive-Euclid GCD engine for two unsigned WIDTH-bit operands. It sits directly upstream of the GCD datapath's enable-gated operand and result registers. It generates their load enables and next values from an internal FSM, and exposes a start/ready/done handshake to the ISE top level. Each run performs one compare-and-subtract per clock until the operands converge.

## Interface
- WIDTH, 32, operand and result width in bits (≥2)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request a computation; accepted only while ready=1
- a_in  input  WIDTH  first operand, sampled on the accepting edge
- b_in  input  WIDTH  second operand, sampled on the accepting edge
- ready  output  1  high in IDLE only
- done  output  1  one-cycle pulse marking result valid
- result  output  WIDTH  last computed GCD, held until next completion
- iters  output  WIDTH  subtraction count of last run (only with GCD_ITER_COUNT_EN)

## Operation
- Reset values: state=IDLE, ready=1, done=0, result=0, iters=0, A=B=0.
- States: IDLE, RUN, DONE.
- IDLE: if start=1 at an edge, A←a_in, B←b_in, iteration count←0, go to RUN. Otherwise hold.
- RUN, one decision per edge, in priority order:
  - A==0: result←B, go to DONE.
  - B==0: result←A, go to DONE.
  - A==B: result←A, go to DONE.
  - A>B: A←A−B, stay in RUN.
  - else: B←B−A, stay in RUN.
- DONE: done=1 for exactly this cycle; go to IDLE at the next edge unconditionally.
- Arithmetic: unsigned compare and subtract, WIDTH bits. Subtraction is only ever larger minus smaller, so it never underflows.
- gcd(0,0)=0. gcd(0,x)=gcd(x,0)=x.
- start while ready=0, including in the DONE cycle, is ignored and not queued.
- a_in and b_in are don't-care except on the accepting edge.
- result changes only on the RUN→DONE edge or on reset.

## Timing
- Start sampled at edge E0 with N subtractions needed: state is RUN after E0, DONE after E(N+1), and done is high during the cycle following E(N+1).
- ready returns high after E(N+2).
- Throughput: a new start can be accepted at E(N+2), giving a minimum spacing of N+2 cycles between runs.
- Reset asserted at any edge overrides everything. The engine is in IDLE with reset values after that edge and the in-flight run is discarded.

## Configuration
- GCD_ITER_COUNT_EN defined:
  - An internal WIDTH-bit counter increments once per subtraction edge and saturates at all-ones.
  - iters is loaded from the counter on the RUN→DONE edge and held like result; reset value 0.
- Not defined: no counter and no iters port. All other behaviour is identical.

## Structure
- Shared package gcd_pkg:
  - state enumeration (IDLE, RUN, DONE)
  - default WIDTH constant
- One natural sub-module, gcd_fsm:
  - holds the state register
  - takes the A==0, B==0, A==B and A>B flags
  - produces ready, done, operand load enables and the result load enable
- The operand and result registers plus the subtractors stay in gcd_engine.

## Test plan
- a=12, b=12 -> done after E1, result=12, iters=0, ready high after E2.
- a=48, b=18 -> sequence (30,18),(12,18),(12,6),(6,6); done after E5, result=6, iters=4.
- a=0, b=9 -> result=9 after E1; then a=0, b=0 -> result=0 after E1 of that run.
- start pulsed with a=7, b=5 mid-run of 48/18, and again during the DONE cycle -> both ignored; result=6 and operands unchanged.
- WIDTH=8 instance, a=255, b=1 -> 254 subtractions, done after E255, result=1, iters=254.
- reset at E2 of the 48/18 run -> after that edge ready=1, done=0, result=0; a fresh start with a=10, b=4 yields result=2 after E4.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared definitions for the subtractive-Euclid GCD engine.
//   GcdWidth    : default operand/result width
//   gcd_state_e : engine FSM states
package gcd_pkg;

  localparam int unsigned GcdWidth = 32;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } gcd_state_e;

endpackage

// File: rtl/gcd_engine_if.sv
// Start/ready/done handshake between the ISE top level and gcd_engine.
//   master : requester side (drives start, a_in, b_in)
//   slave  : engine side (drives ready, done, result and, optionally, iters)
// Optional feature macro: GCD_ITER_COUNT_EN adds the iters signal.
interface gcd_engine_if
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = GcdWidth
);

  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result;

`ifdef GCD_ITER_COUNT_EN
  logic [WIDTH-1:0] iters;

  modport master (
    output start, a_in, b_in,
    input  ready, done, result, iters
  );

  modport slave (
    input  start, a_in, b_in,
    output ready, done, result, iters
  );
`else
  modport master (
    output start, a_in, b_in,
    input  ready, done, result
  );

  modport slave (
    input  start, a_in, b_in,
    output ready, done, result
  );
`endif

endinterface

// File: rtl/gcd_fsm.sv
// Control FSM for gcd_engine: IDLE -> RUN (one compare/subtract per clock) -> DONE.
//   clk, reset  : clock, synchronous active-high reset
//   start       : request, honoured only in IDLE
//   a_zero, b_zero, a_eq_b, a_gt_b : operand comparison flags
//   ready, done : handshake outputs (IDLE / DONE cycle)
//   load_ops    : capture a_in/b_in into the operand registers
//   sub_a/sub_b : A <= A-B / B <= B-A
//   load_res    : capture result; res_sel_b picks B instead of A
module gcd_fsm
  import gcd_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic a_zero,
  input  logic b_zero,
  input  logic a_eq_b,
  input  logic a_gt_b,
  output logic ready,
  output logic done,
  output logic load_ops,
  output logic sub_a,
  output logic sub_b,
  output logic load_res,
  output logic res_sel_b
);

  gcd_state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ready     = 1'b0;
    done      = 1'b0;
    load_ops  = 1'b0;
    sub_a     = 1'b0;
    sub_b     = 1'b0;
    load_res  = 1'b0;
    res_sel_b = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        if (start) begin
          load_ops = 1'b1;
          state_d  = StRun;
        end
      end
      StRun: begin
        // Terminal checks take priority over subtraction so a zero operand never loops.
        if (a_zero) begin
          load_res  = 1'b1;
          res_sel_b = 1'b1;
          state_d   = StDone;
        end else if (b_zero || a_eq_b) begin
          load_res = 1'b1;
          state_d  = StDone;
        end else if (a_gt_b) begin
          sub_a = 1'b1;
        end else begin
          sub_b = 1'b1;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: rtl/gcd_engine.sv
// Iterative subtractive-Euclid GCD engine with operand/result registers.
//   clk, reset : clock, synchronous active-high reset
//   bus        : gcd_engine_if slave (start, a_in, b_in -> ready, done, result[, iters])
// Optional feature macro: GCD_ITER_COUNT_EN adds a saturating subtraction counter
// whose value at completion is presented on bus.iters.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = GcdWidth
) (
  input logic         clk,
  input logic         reset,
  gcd_engine_if.slave bus
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;

  logic a_zero, b_zero, a_eq_b, a_gt_b;
  logic ready, done, load_ops, sub_a, sub_b, load_res, res_sel_b;

  assign a_zero = (a_q == '0);
  assign b_zero = (b_q == '0);
  assign a_eq_b = (a_q == b_q);
  assign a_gt_b = (a_q > b_q);

  gcd_fsm u_fsm (
    .clk       (clk),
    .reset     (reset),
    .start     (bus.start),
    .a_zero    (a_zero),
    .b_zero    (b_zero),
    .a_eq_b    (a_eq_b),
    .a_gt_b    (a_gt_b),
    .ready     (ready),
    .done      (done),
    .load_ops  (load_ops),
    .sub_a     (sub_a),
    .sub_b     (sub_b),
    .load_res  (load_res),
    .res_sel_b (res_sel_b)
  );

  // Subtraction is always larger minus smaller, guaranteed by the FSM's flag decode.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    res_d = res_q;
    if (load_ops) begin
      a_d = bus.a_in;
      b_d = bus.b_in;
    end else if (sub_a) begin
      a_d = a_q - b_q;
    end else if (sub_b) begin
      b_d = b_q - a_q;
    end
    if (load_res) begin
      res_d = res_sel_b ? b_q : a_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      res_q <= res_d;
    end
  end

  assign bus.ready  = ready;
  assign bus.done   = done;
  assign bus.result = res_q;

`ifdef GCD_ITER_COUNT_EN
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] iters_q, iters_d;

  always_comb begin
    cnt_d   = cnt_q;
    iters_d = iters_q;
    if (load_ops) begin
      cnt_d = '0;
    end else if ((sub_a || sub_b) && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (load_res) begin
      iters_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      iters_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      iters_q <= iters_d;
    end
  end

  assign bus.iters = iters_q;
`endif

endmodule
